// File: rtl/dfa_sequence_detector_pkg.sv
// dfa_pkg: shared FSM state encodings and sizing helpers for the serial pattern detector.
package dfa_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'b01,
        ARMED = 2'b10
    } state_e;

    function automatic int fill_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/dfa_sequence_detector_if.sv
// dfa_sequence_detector_if: serial-bit, pattern-control and match-status bundle of the detector.
interface dfa_sequence_detector_if #(
    parameter int PATTERN_WIDTH = 2,
    parameter int COUNT_WIDTH   = 8
);

    logic                     input_sequence;
    logic                     input_valid;
    logic [PATTERN_WIDTH-1:0] pattern_in;
    logic                     pattern_load;
    logic                     overlap_mode;
    logic                     count_clear;
    logic                     condition_met;
    logic [COUNT_WIDTH-1:0]   match_count;
    logic                     count_saturated;

    modport master (
        output input_sequence, input_valid, pattern_in, pattern_load, overlap_mode, count_clear,
        input  condition_met, match_count, count_saturated
    );

    modport slave (
        input  input_sequence, input_valid, pattern_in, pattern_load, overlap_mode, count_clear,
        output condition_met, match_count, count_saturated
    );

endinterface

// File: rtl/dfa_sequence_detector_match_counter.sv
// dfa_match_counter: saturating match counter; a clear coinciding with an increment yields 1.
module dfa_match_counter #(
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_clear,
    input  logic                   i_inc,
    output logic [COUNT_WIDTH-1:0] o_count,
    output logic                   o_saturated
);

    logic [COUNT_WIDTH-1:0] r_count;
    logic                   w_sat;

    assign w_sat       = &r_count;
    assign o_count     = r_count;
    assign o_saturated = w_sat;

    always_ff @(posedge clk) begin
        if (reset)
            r_count <= '0;
        else if (i_clear)
            r_count <= COUNT_WIDTH'(i_inc);
        else if (i_inc && !w_sat)
            r_count <= r_count + 1'b1;
    end

endmodule

// File: rtl/dfa_sequence_detector.sv
// dfa_sequence_detector: compares the last PATTERN_WIDTH accepted serial bits with a loadable
// pattern, flagging matches and counting them, in overlapping or non-overlapping mode.
module dfa_sequence_detector
    import dfa_pkg::*;
#(
    parameter int                       PATTERN_WIDTH   = 2,
    parameter logic [PATTERN_WIDTH-1:0] DEFAULT_PATTERN = PATTERN_WIDTH'(2'b01),
    parameter int                       COUNT_WIDTH     = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    dfa_sequence_detector_if.slave bus
);

    localparam int FW = fill_width(PATTERN_WIDTH);

    logic [PATTERN_WIDTH-1:0] r_pattern;
    logic [PATTERN_WIDTH-1:0] r_history;
    logic [FW-1:0]            r_fill;
    state_e                   r_state;
    logic                     r_condition_met;

    logic                     w_accept;
    logic [PATTERN_WIDTH-1:0] w_next_history;
    logic [FW-1:0]            w_next_fill;
    logic                     w_full;
    logic                     w_match;
    logic [COUNT_WIDTH-1:0]   w_count;
    logic                     w_saturated;

    assign w_accept       = bus.input_valid && !bus.pattern_load;
    assign w_next_history = {r_history[PATTERN_WIDTH-2:0], bus.input_sequence};
    assign w_next_fill    = (r_fill == FW'(PATTERN_WIDTH)) ? r_fill : r_fill + 1'b1;
    // Window is complete either when already armed or when this sample supplies the last missing bit.
    assign w_full         = (r_state == ARMED) || (r_fill == FW'(PATTERN_WIDTH - 1));
    assign w_match        = w_accept && w_full && (w_next_history == r_pattern);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pattern       <= DEFAULT_PATTERN;
            r_history       <= '0;
            r_fill          <= '0;
            r_state         <= FILL;
            r_condition_met <= 1'b0;
        end else if (bus.pattern_load) begin
            r_pattern       <= bus.pattern_in;
            r_history       <= '0;
            r_fill          <= '0;
            r_state         <= FILL;
            r_condition_met <= 1'b0;
        end else if (w_accept) begin
            r_history       <= w_next_history;
            r_condition_met <= w_match;
            if (w_match && !bus.overlap_mode) begin
                r_fill  <= '0;
                r_state <= FILL;
            end else begin
                r_fill  <= w_next_fill;
                r_state <= (w_next_fill == FW'(PATTERN_WIDTH)) ? ARMED : FILL;
            end
        end
    end

    dfa_match_counter #(
        .COUNT_WIDTH (COUNT_WIDTH)
    ) u_counter (
        .clk         (clk),
        .reset       (reset),
        .i_clear     (bus.count_clear),
        .i_inc       (w_match),
        .o_count     (w_count),
        .o_saturated (w_saturated)
    );

    assign bus.condition_met   = r_condition_met;
    assign bus.match_count     = w_count;
    assign bus.count_saturated = w_saturated;

endmodule
